// File: rtl/spi_master_pkg.sv
// spi_master_pkg: shared states, opcodes and frame lengths for the SPI command master
package spi_master_pkg;
    typedef enum logic [2:0] {IDLE, START, CMD, PAYLOAD, GAP, READ, DONE} state_e;
    localparam logic [1:0] OP_WR_ADDR = 2'b00;
    localparam logic [1:0] OP_WR_DATA = 2'b01;
    localparam logic [1:0] OP_RD_ADDR = 2'b10;
    localparam logic [1:0] OP_RD_DATA = 2'b11;
    localparam int PAYLOAD_LEN = 10;
    localparam int READ_LEN = 8;
endpackage

// File: rtl/spi_master_shifter.sv
// spi_master_shifter: parallel-load MOSI shifter and MSB-first MISO capture shifter
module spi_master_shifter
    import spi_master_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load_i,
    input  logic [PAYLOAD_LEN-1:0] load_val_i,
    input  logic                   shift_i,
    input  logic                   cap_i,
    input  logic                   miso_i,
    output logic                   mosi_o,
    output logic [READ_LEN-1:0]    cap_o
);
    logic [PAYLOAD_LEN-1:0] tx_q, tx_d;
    logic [READ_LEN-1:0]    cap_q, cap_d;

    always_comb begin
        tx_d = load_i ? load_val_i : shift_i ? {tx_q[PAYLOAD_LEN-2:0], 1'b0} : tx_q;
        cap_d = cap_i ? {cap_q[READ_LEN-2:0], miso_i} : cap_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_q <= '0;
            cap_q <= '0;
        end else begin
            tx_q <= tx_d;
            cap_q <= cap_d;
        end
    end

    assign mosi_o = tx_q[PAYLOAD_LEN-1];
    assign cap_o = cap_q;
endmodule

// File: rtl/spi_master_cmd.sv
// spi_master_cmd: command-driven SPI master sending opcode/byte frames with optional read-back
module spi_master_cmd
    import spi_master_pkg::*;
#(
    parameter int RD_GAP = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [7:0] cmd_data,
    output logic       rd_valid,
    output logic [7:0] rd_data,
    output logic       busy,
    output logic       SS_n,
    output logic       MOSI,
    input  logic       MISO
);
    state_e              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [1:0]          op_q, op_d;
    logic [7:0]          rd_data_q, rd_data_d;
    logic [READ_LEN-1:0] cap;
    logic                accept, last, is_rd, mosi_bit;

    assign accept = cmd_valid && cmd_ready;
    assign last = cnt_q == '0;
    assign is_rd = op_q == OP_RD_DATA;

    spi_master_shifter u_shifter (
        .clk        (clk),
        .rst        (rst),
        .load_i     (accept),
        .load_val_i ({cmd_op, cmd_data}),
        .shift_i    (state_q == PAYLOAD),
        .cap_i      (state_q == READ),
        .miso_i     (MISO),
        .mosi_o     (mosi_bit),
        .cap_o      (cap)
    );

    // Counter counts down to zero and is reloaded whenever a multi-cycle state is entered
    always_comb begin
        state_d = state_q;
        cnt_d = last ? cnt_q : cnt_q - 4'd1;
        op_d = op_q;
        case (state_q)
            IDLE: if (accept) begin
                state_d = START;
                op_d = cmd_op;
            end
            START: state_d = CMD;
            CMD: begin
                state_d = PAYLOAD;
                cnt_d = 4'(PAYLOAD_LEN - 1);
            end
            PAYLOAD: if (last) begin
                state_d = is_rd ? GAP : DONE;
                cnt_d = is_rd ? 4'(RD_GAP - 1) : '0;
            end
            GAP: if (last) begin
                state_d = READ;
                cnt_d = 4'(READ_LEN - 1);
            end
            READ: if (last) state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The captured byte is shown directly during DONE and held in rd_data_q afterwards
    assign rd_data_d = rd_valid ? cap : rd_data_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q <= '0;
            op_q <= '0;
            rd_data_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            op_q <= op_d;
            rd_data_q <= rd_data_d;
        end
    end

    assign cmd_ready = state_q == IDLE;
    assign busy = !cmd_ready;
    assign SS_n = (state_q == IDLE) || (state_q == DONE);
    assign MOSI = (state_q == CMD) ? op_q[1] : (state_q == PAYLOAD) && mosi_bit;
    assign rd_valid = (state_q == DONE) && is_rd;
    assign rd_data = rd_data_d;
endmodule
